// File: rtl/frame_loss_monitor.sv
// Per-round frame loss monitor: parses segment/round fields from the RX byte stream,
// marks arrivals in a ping-pong bitmap and scans the previous round's bank in parallel.
module frame_loss_monitor #(
   parameter int SEG_W      = 12,
   parameter int SEG_POS    = 16,
   parameter int AUX_POS    = 18,
   parameter int MAX_AUX    = 255,
   parameter int MAX_ROUNDS = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] segment_number_max,
   input  logic        rx_en,
   input  logic [7:0]  rx_data,
   input  logic        rx_err,
   output logic [31:0] count,
   output logic [31:0] ok,
   output logic [31:0] ng,
   output logic [31:0] dup,
   output logic [31:0] bad_seg,
   output logic [31:0] stale,
   output logic [31:0] rounds,
   output logic [15:0] round_lost,
   output logic        round_done,
   output logic        overrun,
   output logic [2:0]  state
);

   localparam int DEPTH   = 1 << SEG_W;
   localparam int LEN_MIN = (SEG_POS + 1 > AUX_POS) ? SEG_POS + 1 : AUX_POS;
   localparam logic [SEG_W:0] INIT_ONE = 1;

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_IDLE = 3'd1,
      S_SYNC = 3'd2,
      S_RUN  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t st, st_next;
   assign state = st;

   function automatic logic [31:0] inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   // Frame parser
   logic        rx_en_q, err_q;
   logic [15:0] byte_cnt;
   logic [7:0]  seg_hi, seg_lo, aux_b;
   logic [15:0] seg;
   assign seg = {seg_hi, seg_lo};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_en_q  <= 1'b0;
         err_q    <= 1'b0;
         byte_cnt <= '0;
         seg_hi   <= '0;
         seg_lo   <= '0;
         aux_b    <= '0;
      end else begin
         rx_en_q <= rx_en;
         if (rx_en) begin
            if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
            if (rx_err) err_q <= 1'b1;
            if (byte_cnt == 16'(SEG_POS))     seg_hi <= rx_data;
            if (byte_cnt == 16'(SEG_POS + 1)) seg_lo <= rx_data;
            if (byte_cnt == 16'(AUX_POS))     aux_b  <= rx_data;
         end else begin
            // Length and error flag stay valid through the frame-end cycle.
            byte_cnt <= '0;
            err_q    <= 1'b0;
         end
      end
   end

   // Control and scan state
   logic             bank_sel, auto_go;
   logic [7:0]       cur_aux;
   logic [SEG_W:0]   init_addr;
   logic             scan_iss, sv_vld, sv_last;
   logic [15:0]      scan_addr, round_ng;
   logic [SEG_W-1:0] sv_addr, c1_seg, c2_seg;
   logic             c1_vld, c2_vld;
   logic             busy;
   assign busy = scan_iss | sv_vld;

   // Commit classification, evaluated in the cycle after rx_en falls
   logic       frame_ok, cm_go, cm_bad, cm_same, cm_next, cm_swap, cm_over, cm_stale;
   logic [7:0] eff_cur, nxt_aux;
   logic       round_last, max_hit;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      frame_ok = rx_en_q && !rx_en && (byte_cnt > 16'(LEN_MIN)) && !err_q;
      cm_go    = frame_ok && !start && (st == S_RUN || (st == S_SYNC && aux_b == 8'd0));
      eff_cur  = (st == S_SYNC) ? 8'd0 : cur_aux;
      nxt_aux  = (eff_cur == 8'(MAX_AUX)) ? 8'd0 : eff_cur + 8'd1;
      cm_bad   = cm_go && (seg >= segment_number_max);
      cm_same  = cm_go && !cm_bad && (aux_b == eff_cur);
      cm_next  = cm_go && !cm_bad && !cm_same && (aux_b == nxt_aux);
      cm_swap  = cm_next && !busy;
      cm_over  = cm_next && busy;
      cm_stale = (cm_go && !cm_bad && !cm_same && !cm_next) || cm_over;
      round_last = sv_vld && sv_last;
      max_hit    = (MAX_ROUNDS != 0) && (rounds == 32'(MAX_ROUNDS - 1));
   end

   always_comb begin
      st_next = st;
      case (st)
         S_INIT: if (&init_addr) st_next = S_IDLE;
         S_IDLE: if (start || auto_go) st_next = S_SYNC;
         S_SYNC: if (cm_go) st_next = S_RUN;
         S_RUN:  if (round_last && max_hit) st_next = S_DONE;
         default: st_next = st;
      endcase
      if (start && st != S_INIT && st != S_IDLE) st_next = S_INIT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= S_INIT;
      else        st <= st_next;
   end

   // Bitmap banks: the active bank serves commits, the other serves the scan or INIT sweep
   logic [1:0]       b_we, b_wdata, b_rdata;
   logic [SEG_W-1:0] b_waddr [2];
   logic [SEG_W-1:0] b_raddr [2];
   logic             bank0 [DEPTH];
   logic             bank1 [DEPTH];

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         b_we[b]    = 1'b0;
         b_wdata[b] = 1'b0;
         b_waddr[b] = '0;
         b_raddr[b] = '0;
         if (st == S_INIT) begin
            b_we[b]    = (init_addr[SEG_W] == 1'(b));
            b_waddr[b] = init_addr[SEG_W-1:0];
         end else if (bank_sel == 1'(b)) begin
            b_raddr[b] = c1_seg;
            b_we[b]    = c2_vld && !b_rdata[b];
            b_waddr[b] = c2_seg;
            b_wdata[b] = 1'b1;
         end else begin
            b_raddr[b] = scan_addr[SEG_W-1:0];
            b_we[b]    = sv_vld;
            b_waddr[b] = sv_addr;
         end
      end
   end

   // NOTE: bitmap storage has no reset; the INIT sweep clears it after every reset or restart.
   always_ff @(posedge clk) begin
      if (b_we[0]) bank0[b_waddr[0]] <= b_wdata[0];
      if (b_we[1]) bank1[b_waddr[1]] <= b_wdata[1];
      b_rdata[0] <= bank0[b_raddr[0]];
      b_rdata[1] <= bank1[b_raddr[1]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0; ok <= '0; ng <= '0; dup <= '0;
         bad_seg <= '0; stale <= '0; rounds <= '0; round_lost <= '0;
         round_done <= 1'b0; overrun <= 1'b0;
         bank_sel <= 1'b0; auto_go <= 1'b0; cur_aux <= '0; init_addr <= '0;
         scan_iss <= 1'b0; scan_addr <= '0; round_ng <= '0;
         sv_vld <= 1'b0; sv_last <= 1'b0; sv_addr <= '0;
         c1_vld <= 1'b0; c1_seg <= '0; c2_vld <= 1'b0; c2_seg <= '0;
      end else begin
         round_done <= 1'b0;
         init_addr  <= (st == S_INIT) ? init_addr + INIT_ONE : '0;
         if (st == S_IDLE) auto_go <= 1'b0;

         if (start && st != S_INIT) begin
            count <= '0; ok <= '0; ng <= '0; dup <= '0;
            bad_seg <= '0; stale <= '0; rounds <= '0; round_lost <= '0;
            overrun <= 1'b0;
            scan_iss <= 1'b0; sv_vld <= 1'b0; c1_vld <= 1'b0; c2_vld <= 1'b0;
            if (st != S_IDLE) auto_go <= 1'b1;
         end else begin
            // Commit pipeline: read the active bank, then set the bit or count a duplicate
            c1_vld <= cm_same || cm_swap;
            c1_seg <= seg[SEG_W-1:0];
            c2_vld <= c1_vld;
            c2_seg <= c1_seg;
            if (c2_vld && b_rdata[bank_sel]) dup <= inc32(dup);
            if (cm_go && st == S_SYNC) cur_aux <= 8'd0;
            if (cm_bad)   bad_seg <= inc32(bad_seg);
            if (cm_stale) stale   <= inc32(stale);
            if (cm_over)  overrun <= 1'b1;

            sv_vld  <= scan_iss;
            sv_addr <= scan_addr[SEG_W-1:0];
            sv_last <= (scan_addr == segment_number_max - 16'd1);
            if (scan_iss) begin
               scan_addr <= scan_addr + 16'd1;
               if (scan_addr == segment_number_max - 16'd1) scan_iss <= 1'b0;
            end

            if (cm_swap) begin
               cur_aux   <= aux_b;
               bank_sel  <= ~bank_sel;
               scan_iss  <= 1'b1;
               scan_addr <= '0;
               round_ng  <= '0;
            end

            if (sv_vld) begin
               count <= inc32(count);
               if (b_rdata[~bank_sel]) ok <= inc32(ok);
               else begin
                  ng       <= inc32(ng);
                  round_ng <= inc16(round_ng);
               end
               if (sv_last) begin
                  round_lost <= b_rdata[~bank_sel] ? round_ng : inc16(round_ng);
                  rounds     <= inc32(rounds);
                  round_done <= 1'b1;
               end
            end
         end
      end
   end

endmodule
